// File: rtl/uart_pkg.sv
// Shared UART definitions: parity modes, receiver state encodings, width helper.
package uart_pkg;

    localparam int unsigned PARITY_NONE = 0;
    localparam int unsigned PARITY_ODD  = 1;
    localparam int unsigned PARITY_EVEN = 2;

    // Receiver FSM encodings
    localparam logic [2:0] RX_IDLE   = 3'd0;
    localparam logic [2:0] RX_START  = 3'd1;
    localparam logic [2:0] RX_DATA   = 3'd2;
    localparam logic [2:0] RX_PARITY = 3'd3;
    localparam logic [2:0] RX_STOP   = 3'd4;

    // Bits needed to hold values 0..v-1, never less than 1
    function automatic int unsigned clog2_w(input int unsigned v);
        return (v <= 2) ? 1 : $clog2(v);
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO with registered head; overflowing pushes are dropped unless a pop coincides.
module sync_fifo
    import uart_pkg::*;
#(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic [WIDTH-1:0]           push_data,
    input  logic                       pop,
    output logic [WIDTH-1:0]           head_data,
    output logic                       full,
    output logic                       empty,
    output logic [clog2_w(DEPTH):0]    count
);

    localparam int unsigned AW = clog2_w(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW:0]      wptr_q;
    logic [AW:0]      rptr_q;
    logic             do_push;
    logic             do_pop;

    // Occupancy, flags and push/pop qualification; a full FIFO accepts a push only alongside a pop
    always_comb begin
        count     = wptr_q - rptr_q;
        full      = (count == (AW + 1)'(DEPTH));
        empty     = (count == '0);
        do_pop    = pop & ~empty;
        do_push   = push & (~full | do_pop);
        head_data = empty ? '0 : mem_q[rptr_q[AW-1:0]];
    end

    // Pointer update; the extra top bit distinguishes full from empty
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            if (do_push) wptr_q <= wptr_q + (AW + 1)'(1);
            if (do_pop)  rptr_q <= rptr_q + (AW + 1)'(1);
        end
    end

    // Storage write; contents are don't-care while empty since the head is masked
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wptr_q[AW-1:0]] <= push_data;
    end

endmodule

// File: rtl/uart_rx_fifo.sv
// UART receiver (5-9 data bits, optional parity, 1/2 stop bits) feeding a small FIFO.
module uart_rx_fifo
    import uart_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 1666,
    parameter int unsigned DATA_BITS    = 8,
    parameter int unsigned PARITY       = 0,
    parameter int unsigned STOP_BITS    = 1,
    parameter int unsigned FIFO_DEPTH   = 4
) (
    input  logic                           i_uart_clk,
    input  logic                           i_rst,
    input  logic                           i_rx_data,
    input  logic                           i_rx_ready,
    input  logic                           i_clr_overrun,
    output logic                           o_rx_active,
    output logic [DATA_BITS-1:0]           o_byte_out,
    output logic                           o_frame_err,
    output logic                           o_parity_err,
    output logic                           o_data_valid,
    output logic                           o_overrun,
    output logic [$clog2(FIFO_DEPTH):0]    o_fifo_count
);

    localparam int unsigned CNT_W   = clog2_w(CLKS_PER_BIT);
    localparam int unsigned IDX_W   = clog2_w(DATA_BITS);
    localparam int unsigned ENTRY_W = DATA_BITS + 2;
    localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_BITS - 1);

    logic                 sync1_q, rx_s_q, prev_q;
    logic [2:0]           state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [IDX_W-1:0]     idx_q, idx_d;
    logic [DATA_BITS-1:0] shreg_q, shreg_d;
    logic                 par_err_q, par_err_d;
    logic                 frame_err_q, frame_err_d;
    logic                 push_q, push_d;
    logic [ENTRY_W-1:0]   push_data_q, push_data_d;
    logic                 overrun_q;
    logic [ENTRY_W-1:0]   head;
    logic                 fifo_full, fifo_empty, pop;

    // Two-flop synchroniser plus previous-sample register for falling-edge detection
    always_ff @(posedge i_uart_clk or posedge i_rst) begin
        if (i_rst) begin
            sync1_q <= 1'b1;
            rx_s_q  <= 1'b1;
            prev_q  <= 1'b1;
        end else begin
            sync1_q <= i_rx_data;
            rx_s_q  <= sync1_q;
            prev_q  <= rx_s_q;
        end
    end

    // Frame FSM: mid-bit sampling driven by a down-counting bit timer
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        idx_d       = idx_q;
        shreg_d     = shreg_q;
        par_err_d   = par_err_q;
        frame_err_d = frame_err_q;
        push_d      = 1'b0;
        push_data_d = push_data_q;
        case (state_q)
            RX_IDLE: begin
                if (prev_q && !rx_s_q) begin
                    cnt_d   = CNT_HALF;
                    state_d = RX_START;
                end
            end
            RX_START: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CNT_W'(1);
                end else if (rx_s_q) begin
                    state_d = RX_IDLE;
                end else begin
                    cnt_d       = CNT_FULL;
                    idx_d       = '0;
                    par_err_d   = 1'b0;
                    frame_err_d = 1'b0;
                    state_d     = RX_DATA;
                end
            end
            RX_DATA: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CNT_W'(1);
                end else begin
                    shreg_d[idx_q] = rx_s_q;
                    cnt_d          = CNT_FULL;
                    if (idx_q == IDX_LAST) begin
                        idx_d   = '0;
                        state_d = (PARITY != PARITY_NONE) ? RX_PARITY : RX_STOP;
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end
            end
            RX_PARITY: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CNT_W'(1);
                end else begin
                    // Odd mode wants an odd total of ones over data plus parity bit
                    par_err_d = ((^shreg_q) ^ rx_s_q) != (PARITY == PARITY_ODD);
                    cnt_d     = CNT_FULL;
                    state_d   = RX_STOP;
                end
            end
            RX_STOP: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CNT_W'(1);
                end else if (STOP_BITS == 2 && idx_q == '0) begin
                    frame_err_d = frame_err_q | ~rx_s_q;
                    idx_d       = IDX_W'(1);
                    cnt_d       = CNT_FULL;
                end else begin
                    push_d      = 1'b1;
                    push_data_d = {frame_err_q | ~rx_s_q, par_err_q, shreg_q};
                    state_d     = RX_IDLE;
                end
            end
            default: state_d = RX_IDLE;
        endcase
    end

    // FSM state registers; reset discards any partial frame
    always_ff @(posedge i_uart_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q     <= RX_IDLE;
            cnt_q       <= '0;
            idx_q       <= '0;
            shreg_q     <= '0;
            par_err_q   <= 1'b0;
            frame_err_q <= 1'b0;
            push_q      <= 1'b0;
            push_data_q <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            idx_q       <= idx_d;
            shreg_q     <= shreg_d;
            par_err_q   <= par_err_d;
            frame_err_q <= frame_err_d;
            push_q      <= push_d;
            push_data_q <= push_data_d;
        end
    end

    // Sticky overrun: a dropped push (full and no pop) wins over a clear
    always_ff @(posedge i_uart_clk or posedge i_rst) begin
        if (i_rst) begin
            overrun_q <= 1'b0;
        end else if (push_q && fifo_full && !pop) begin
            overrun_q <= 1'b1;
        end else if (i_clr_overrun) begin
            overrun_q <= 1'b0;
        end
    end

    sync_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (i_uart_clk),
        .rst       (i_rst),
        .push      (push_q),
        .push_data (push_data_q),
        .pop       (pop),
        .head_data (head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (o_fifo_count)
    );

    // Output mapping; active stays high through the push cycle
    always_comb begin
        pop          = ~fifo_empty & i_rx_ready;
        o_data_valid = ~fifo_empty;
        o_byte_out   = head[DATA_BITS-1:0];
        o_parity_err = head[DATA_BITS];
        o_frame_err  = head[DATA_BITS+1];
        o_overrun    = overrun_q;
        o_rx_active  = (state_q != RX_IDLE) | push_q;
    end

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed bench for uart_rx_fifo: an 8N1 instance and an 8E1 instance, CLKS_PER_BIT=4.
module tb_uart_rx_fifo;

    logic       clk = 1'b0;
    logic       rst;
    logic       rx, rx_p, rdy, rdy_p, clr, clr_p;
    logic       active, fe, pe, valid, ovr;
    logic       active_p, fe_p, pe_p, valid_p, ovr_p;
    logic [7:0] byte_out, byte_out_p;
    logic [2:0] count, count_p;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    uart_rx_fifo #(
        .CLKS_PER_BIT (4), .DATA_BITS (8), .PARITY (0), .STOP_BITS (1), .FIFO_DEPTH (4)
    ) dut (
        .i_uart_clk (clk), .i_rst (rst), .i_rx_data (rx), .i_rx_ready (rdy),
        .i_clr_overrun (clr), .o_rx_active (active), .o_byte_out (byte_out),
        .o_frame_err (fe), .o_parity_err (pe), .o_data_valid (valid),
        .o_overrun (ovr), .o_fifo_count (count)
    );

    uart_rx_fifo #(
        .CLKS_PER_BIT (4), .DATA_BITS (8), .PARITY (2), .STOP_BITS (1), .FIFO_DEPTH (4)
    ) dut_p (
        .i_uart_clk (clk), .i_rst (rst), .i_rx_data (rx_p), .i_rx_ready (rdy_p),
        .i_clr_overrun (clr_p), .o_rx_active (active_p), .o_byte_out (byte_out_p),
        .o_frame_err (fe_p), .o_parity_err (pe_p), .o_data_valid (valid_p),
        .o_overrun (ovr_p), .o_fifo_count (count_p)
    );

    typedef struct {
        logic [11:0] frame;
        int          nbits;
        bit          par;
        logic [7:0]  exp_byte;
        bit          exp_fe;
        bit          exp_pe;
    } vec_t;

    vec_t vecs [10];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    // Line bits LSB first: start, data, stop
    function automatic logic [11:0] mk8(input logic [7:0] d, input logic stop);
        return {2'b11, stop, d, 1'b0};
    endfunction

    // Start, data, parity, stop
    function automatic logic [11:0] mkp(input logic [7:0] d, input logic p, input logic stop);
        return {1'b1, stop, p, d, 1'b0};
    endfunction

    // Called #1 after a posedge; returns #1 after the posedge ending the last bit
    task automatic send(input logic [11:0] f, input int n, input bit p, input bit end_high);
        for (int i = 0; i < n; i++) begin
            if (p) rx_p = f[i]; else rx = f[i];
            repeat (4) @(posedge clk);
            #1;
        end
        if (end_high) begin
            if (p) rx_p = 1'b1; else rx = 1'b1;
        end
    endtask

    task automatic pop_one(input bit p);
        if (p) rdy_p = 1'b1; else rdy = 1'b1;
        @(posedge clk);
        #1;
        rdy   = 1'b0;
        rdy_p = 1'b0;
    endtask

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        bit          saw;
        logic [11:0] f;
        logic [7:0]  expq [4];

        vecs[0] = '{mk8(8'h41, 1'b1), 10, 1'b0, 8'h41, 1'b0, 1'b0};
        vecs[1] = '{mk8(8'hA5, 1'b1), 10, 1'b0, 8'hA5, 1'b0, 1'b0};
        vecs[2] = '{mk8(8'h00, 1'b1), 10, 1'b0, 8'h00, 1'b0, 1'b0};
        vecs[3] = '{mk8(8'hFF, 1'b1), 10, 1'b0, 8'hFF, 1'b0, 1'b0};
        vecs[4] = '{mk8(8'h3C, 1'b0), 10, 1'b0, 8'h3C, 1'b1, 1'b0};
        vecs[5] = '{mkp(8'h41, 1'b1, 1'b1), 11, 1'b1, 8'h41, 1'b0, 1'b1};
        vecs[6] = '{mkp(8'h41, 1'b0, 1'b1), 11, 1'b1, 8'h41, 1'b0, 1'b0};
        vecs[7] = '{mkp(8'h80, 1'b1, 1'b1), 11, 1'b1, 8'h80, 1'b0, 1'b0};
        vecs[8] = '{mkp(8'h80, 1'b0, 1'b1), 11, 1'b1, 8'h80, 1'b0, 1'b1};
        vecs[9] = '{mkp(8'h55, 1'b0, 1'b0), 11, 1'b1, 8'h55, 1'b1, 1'b0};

        rst = 1'b1; rx = 1'b1; rx_p = 1'b1;
        rdy = 1'b0; rdy_p = 1'b0; clr = 1'b0; clr_p = 1'b0;
        cycles(3);
        chk("reset_valid", int'(valid), 0);
        chk("reset_count", int'(count), 0);
        chk("reset_active", int'(active), 0);
        chk("reset_overrun", int'(ovr), 0);
        chk("reset_byte", int'(byte_out), 0);
        rst = 1'b0;
        cycles(4);

        // Table: one frame, exact push latency, head fields, then pop back to empty
        for (int v = 0; v < 10; v++) begin
            send(vecs[v].frame, vecs[v].nbits, vecs[v].par, 1'b1);
            cycles(1);
            chk($sformatf("v%0d_valid_early", v), int'(vecs[v].par ? valid_p : valid), 0);
            cycles(1);
            chk($sformatf("v%0d_valid", v), int'(vecs[v].par ? valid_p : valid), 1);
            chk($sformatf("v%0d_byte", v), int'(vecs[v].par ? byte_out_p : byte_out),
                int'(vecs[v].exp_byte));
            chk($sformatf("v%0d_fe", v), int'(vecs[v].par ? fe_p : fe), int'(vecs[v].exp_fe));
            chk($sformatf("v%0d_pe", v), int'(vecs[v].par ? pe_p : pe), int'(vecs[v].exp_pe));
            chk($sformatf("v%0d_count", v), int'(vecs[v].par ? count_p : count), 1);
            pop_one(vecs[v].par);
            chk($sformatf("v%0d_popped_valid", v), int'(vecs[v].par ? valid_p : valid), 0);
            chk($sformatf("v%0d_popped_count", v), int'(vecs[v].par ? count_p : count), 0);
            cycles(4);
        end

        // False start: one-clock low glitch
        rx = 1'b0;
        cycles(1);
        rx  = 1'b1;
        saw = 1'b0;
        for (int i = 0; i < 10; i++) begin
            cycles(1);
            if (active) saw = 1'b1;
        end
        chk("glitch_active_pulse", int'(saw), 1);
        chk("glitch_active_end", int'(active), 0);
        chk("glitch_count", int'(count), 0);

        // Low stop bit followed by a 40-clock break: one entry, no retrigger
        send(mk8(8'h33, 1'b0), 10, 1'b0, 1'b0);
        cycles(40);
        rx = 1'b1;
        cycles(20);
        chk("break_count", int'(count), 1);
        chk("break_byte", int'(byte_out), 'h33);
        chk("break_fe", int'(fe), 1);
        chk("break_active", int'(active), 0);
        cycles(20);
        chk("break_no_retrigger", int'(count), 1);
        pop_one(1'b0);
        chk("break_popped", int'(count), 0);

        // Overrun: five back-to-back frames without popping
        for (int k = 1; k <= 5; k++) send(mk8(8'(k), 1'b1), 10, 1'b0, 1'b1);
        cycles(4);
        chk("ovr_count", int'(count), 4);
        chk("ovr_flag", int'(ovr), 1);
        chk("ovr_head", int'(byte_out), 1);
        cycles(5);
        chk("ovr_sticky", int'(ovr), 1);
        clr = 1'b1;
        cycles(1);
        clr = 1'b0;
        chk("ovr_cleared", int'(ovr), 0);

        // Full FIFO: pop lands in the push cycle of frame 0x06
        send(mk8(8'h06, 1'b1), 10, 1'b0, 1'b1);
        cycles(1);
        rdy = 1'b1;
        cycles(1);
        rdy = 1'b0;
        chk("full_pushpop_count", int'(count), 4);
        chk("full_pushpop_ovr", int'(ovr), 0);
        expq = '{8'h02, 8'h03, 8'h04, 8'h06};
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("order_%0d", i), int'(byte_out), int'(expq[i]));
            pop_one(1'b0);
        end
        chk("drained_valid", int'(valid), 0);
        chk("drained_count", int'(count), 0);
        rdy = 1'b1;
        cycles(3);
        rdy = 1'b0;
        chk("empty_pop_count", int'(count), 0);

        // Reset during the third data bit of 0x5A, with an entry already queued
        send(mk8(8'h77, 1'b1), 10, 1'b0, 1'b1);
        cycles(3);
        chk("pre_rst_valid", int'(valid), 1);
        f = mk8(8'h5A, 1'b1);
        send(f, 3, 1'b0, 1'b0);
        rx = f[3];
        cycles(2);
        chk("pre_rst_active", int'(active), 1);
        rst = 1'b1;
        #1;
        chk("rst_active", int'(active), 0);
        chk("rst_valid", int'(valid), 0);
        chk("rst_count", int'(count), 0);
        chk("rst_byte", int'(byte_out), 0);
        rx = 1'b1;
        cycles(3);
        rst = 1'b0;
        cycles(5);
        chk("post_rst_idle", int'(count), 0);
        send(f, 10, 1'b0, 1'b1);
        cycles(2);
        chk("post_rst_valid", int'(valid), 1);
        chk("post_rst_byte", int'(byte_out), 'h5A);
        chk("post_rst_fe", int'(fe), 0);
        pop_one(1'b0);
        chk("post_rst_popped", int'(count), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
